stream_pipeline: RTL and testbench

//  Parametrised AXI-Stream register pipeline connecting two stream_channel interfaces.

---
 rtl/stream_pkg.sv | 29 ++
 rtl/stream_channel.sv | 33 +++
 rtl/stream_slice.sv | 135 +++++++++++++
 rtl/stream_pipeline.sv | 85 ++++++++
 tb/tb_stream_pipeline.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream register-slice pipeline.
//  stream_slice_mode_e : per-stage type (PASS wire, FORWARD register, FULL skid register)
//  full_state_e        : occupancy states of a FULL stage
//  stream_payload_width: width of the packed payload {id,dest,data,strb,keep,last,user}
package stream_pkg;

  typedef enum logic [1:0] {
    STREAM_SLICE_PASS    = 2'd0,
    STREAM_SLICE_FORWARD = 2'd1,
    STREAM_SLICE_FULL    = 2'd2
  } stream_slice_mode_e;

  typedef enum logic [1:0] {
    FULL_EMPTY = 2'd0,
    FULL_ONE   = 2'd1,
    FULL_TWO   = 2'd2
  } full_state_e;

  function automatic int unsigned stream_payload_width(
    input int unsigned id_w,
    input int unsigned dest_w,
    input int unsigned data_w,
    input int unsigned strb_w,
    input int unsigned user_w
  );
    return id_w + dest_w + data_w + 2 * strb_w + 1 + user_w;
  endfunction

endpackage

// File: rtl/stream_channel.sv
// AXI-Stream channel bundle.
//  Parameters: ID_WIDTH, DATA_WIDTH, DEST_WIDTH, USER_WIDTH (strb/keep are DATA_WIDTH/8).
//  modport master : drives payload and t_valid, receives t_ready
//  modport slave  : receives payload and t_valid, drives t_ready
interface stream_channel #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEST_WIDTH = 4,
  parameter int unsigned USER_WIDTH = 1
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   t_id;
  logic [DEST_WIDTH-1:0] t_dest;
  logic [DATA_WIDTH-1:0] t_data;
  logic [STRB_WIDTH-1:0] t_strb;
  logic [STRB_WIDTH-1:0] t_keep;
  logic                  t_last;
  logic [USER_WIDTH-1:0] t_user;
  logic                  t_valid;
  logic                  t_ready;

  modport master (
    output t_id, t_dest, t_data, t_strb, t_keep, t_last, t_user, t_valid,
    input  t_ready
  );

  modport slave (
    input  t_id, t_dest, t_data, t_strb, t_keep, t_last, t_user, t_valid,
    output t_ready
  );

endinterface

// File: rtl/stream_slice.sv
// One register stage of the stream pipeline, operating on a packed payload.
//  clk, rstn          : clock, asynchronous active-low reset
//  in_valid_i/ready_o : upstream handshake, in_payload_i upstream payload
//  out_valid_o/ready_i: downstream handshake, out_payload_o downstream payload
//  MODE selects PASS (wire), FORWARD (valid/payload registered, combinational
//  ready) or FULL (main + skid register, fully registered in both directions).
module stream_slice
  import stream_pkg::*;
#(
  parameter int unsigned        PAYLOAD_WIDTH = 8,
  parameter stream_slice_mode_e MODE          = STREAM_SLICE_FULL
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [PAYLOAD_WIDTH-1:0] out_payload_o
);

  if (MODE == STREAM_SLICE_PASS) begin : g_pass

    // Clock and reset have no function in a wire stage.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rstn;

    assign out_valid_o   = in_valid_i;
    assign out_payload_o = in_payload_i;
    assign in_ready_o    = out_ready_i;

  end else if (MODE == STREAM_SLICE_FORWARD) begin : g_forward

    logic                     valid_q, valid_d;
    logic [PAYLOAD_WIDTH-1:0] payload_q;

    // Ready stays combinational: the stage can refill in the same cycle it drains.
    assign in_ready_o = !valid_q || out_ready_i;

    always_comb begin
      valid_d = valid_q;
      if (in_ready_o) begin
        valid_d = in_valid_i;
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
      end
    end

    // Payload is deliberately not reset; it is only meaningful while valid_q is set.
    always_ff @(posedge clk) begin
      if (in_valid_i && in_ready_o) begin
        payload_q <= in_payload_i;
      end
    end

    assign out_valid_o   = valid_q;
    assign out_payload_o = payload_q;

  end else begin : g_full

    full_state_e              state_q, state_d;
    logic                     ready_q;
    logic [PAYLOAD_WIDTH-1:0] main_q, main_d;
    logic [PAYLOAD_WIDTH-1:0] skid_q, skid_d;
    logic                     in_hs, out_hs;

    assign in_hs  = in_valid_i && ready_q;
    assign out_hs = out_valid_o && out_ready_i;

    // ready_q mirrors (state != TWO) one edge ahead, so it is a true flop output.
    // Resetting it low keeps the stage closed until the first edge after release.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state_q <= FULL_EMPTY;
        ready_q <= 1'b0;
      end else begin
        state_q <= state_d;
        ready_q <= (state_d != FULL_TWO);
      end
    end

    always_ff @(posedge clk) begin
      main_q <= main_d;
      skid_q <= skid_d;
    end

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
        FULL_EMPTY: begin
          if (in_hs) begin
            state_d = FULL_ONE;
            main_d  = in_payload_i;
          end
        end
        FULL_ONE: begin
          if (in_hs && out_hs) begin
            main_d = in_payload_i;
          end else if (in_hs) begin
            state_d = FULL_TWO;
            skid_d  = in_payload_i;
          end else if (out_hs) begin
            state_d = FULL_EMPTY;
          end
        end
        FULL_TWO: begin
          if (out_hs) begin
            state_d = FULL_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = FULL_EMPTY;
        end
      endcase
    end

    always_comb begin
      out_valid_o   = (state_q != FULL_EMPTY);
      out_payload_o = main_q;
      in_ready_o    = ready_q;
    end

  end

endmodule

// File: rtl/stream_pipeline.sv
// DEPTH-stage AXI-Stream register pipeline between two stream_channel interfaces.
//  clk, rstn : clock, asynchronous active-low reset
//  master    : upstream channel (payload/t_valid in, t_ready out)
//  slave     : downstream channel (payload/t_valid out, t_ready in)
//  DEPTH = 0 connects the channels directly; otherwise DEPTH stream_slice
//  stages of type MODE are chained, each moving the whole payload as one word.
module stream_pipeline
  import stream_pkg::*;
#(
  parameter int unsigned        DEPTH = 1,
  parameter stream_slice_mode_e MODE  = STREAM_SLICE_FULL
) (
  input  logic          clk,
  input  logic          rstn,
  stream_channel.slave  master,
  stream_channel.master slave
);

  localparam int unsigned ID_W   = $bits(master.t_id);
  localparam int unsigned DEST_W = $bits(master.t_dest);
  localparam int unsigned DATA_W = $bits(master.t_data);
  localparam int unsigned STRB_W = $bits(master.t_strb);
  localparam int unsigned USER_W = $bits(master.t_user);
  localparam int unsigned PW     = stream_payload_width(ID_W, DEST_W, DATA_W, STRB_W, USER_W);

  if (ID_W != $bits(slave.t_id) || DATA_W != $bits(slave.t_data) ||
      DEST_W != $bits(slave.t_dest) || USER_W != $bits(slave.t_user)) begin : g_width_check
    $fatal(1, "stream_pipeline: master and slave channel widths differ");
  end

  if (!(MODE inside {STREAM_SLICE_PASS, STREAM_SLICE_FORWARD, STREAM_SLICE_FULL})) begin : g_mode_check
    $fatal(1, "stream_pipeline: unsupported MODE %0d", MODE);
  end

  if (DEPTH == 0) begin : g_wire

    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rstn;

    assign slave.t_id    = master.t_id;
    assign slave.t_dest  = master.t_dest;
    assign slave.t_data  = master.t_data;
    assign slave.t_strb  = master.t_strb;
    assign slave.t_keep  = master.t_keep;
    assign slave.t_last  = master.t_last;
    assign slave.t_user  = master.t_user;
    assign slave.t_valid = master.t_valid;
    assign master.t_ready = slave.t_ready;

  end else begin : g_chain

    // Element k is the input channel of stage k; element DEPTH is the output.
    logic [PW-1:0] chain_payload [DEPTH+1];
    logic          chain_valid   [DEPTH+1];
    logic          chain_ready   [DEPTH+1];

    assign chain_payload[0] = {master.t_id, master.t_dest, master.t_data, master.t_strb,
                               master.t_keep, master.t_last, master.t_user};
    assign chain_valid[0]   = master.t_valid;
    assign master.t_ready   = chain_ready[0];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      stream_slice #(
        .PAYLOAD_WIDTH (PW),
        .MODE          (MODE)
      ) u_slice (
        .clk           (clk),
        .rstn          (rstn),
        .in_valid_i    (chain_valid[k]),
        .in_ready_o    (chain_ready[k]),
        .in_payload_i  (chain_payload[k]),
        .out_valid_o   (chain_valid[k+1]),
        .out_ready_i   (chain_ready[k+1]),
        .out_payload_o (chain_payload[k+1])
      );
    end

    assign {slave.t_id, slave.t_dest, slave.t_data, slave.t_strb,
            slave.t_keep, slave.t_last, slave.t_user} = chain_payload[DEPTH];
    assign slave.t_valid  = chain_valid[DEPTH];
    assign chain_ready[DEPTH] = slave.t_ready;

  end

endmodule

// File: tb/tb_stream_pipeline.sv
// Self-checking bench for stream_pipeline.
//  uA: DEPTH=1 FULL, uB: DEPTH=3 FORWARD, uC: DEPTH=0, uD: DEPTH=2 PASS.
//  Accepted input beats are pushed to a per-DUT queue and popped when the
//  DUT's output handshakes; inputs change 1 time unit after the rising edge,
//  handshakes are sampled on the falling edge.
module tb_stream_pipeline;
  import stream_pkg::*;

  localparam int PW = 50;

  typedef struct {
    logic [PW-1:0] pay;
    int            cyc;
  } beat_t;

  logic clk;
  logic rstn;
  int   cyc;
  int   total;
  int   bad;

  stream_channel #(.ID_WIDTH(4), .DATA_WIDTH(32), .DEST_WIDTH(3), .USER_WIDTH(2)) mA(), sA(), mB(), sB(), mC(), sC(), mD(), sD();

  stream_pipeline #(.DEPTH(1), .MODE(STREAM_SLICE_FULL))    uA (.clk(clk), .rstn(rstn), .master(mA), .slave(sA));
  stream_pipeline #(.DEPTH(3), .MODE(STREAM_SLICE_FORWARD)) uB (.clk(clk), .rstn(rstn), .master(mB), .slave(sB));
  stream_pipeline #(.DEPTH(0), .MODE(STREAM_SLICE_FULL))    uC (.clk(clk), .rstn(rstn), .master(mC), .slave(sC));
  stream_pipeline #(.DEPTH(2), .MODE(STREAM_SLICE_PASS))    uD (.clk(clk), .rstn(rstn), .master(mD), .slave(sD));

  logic [PW-1:0] mAPay, sAPay, mBPay, sBPay, sCPay, sDPay;
  assign mAPay = {mA.t_id, mA.t_dest, mA.t_data, mA.t_strb, mA.t_keep, mA.t_last, mA.t_user};
  assign sAPay = {sA.t_id, sA.t_dest, sA.t_data, sA.t_strb, sA.t_keep, sA.t_last, sA.t_user};
  assign mBPay = {mB.t_id, mB.t_dest, mB.t_data, mB.t_strb, mB.t_keep, mB.t_last, mB.t_user};
  assign sBPay = {sB.t_id, sB.t_dest, sB.t_data, sB.t_strb, sB.t_keep, sB.t_last, sB.t_user};
  assign sCPay = {sC.t_id, sC.t_dest, sC.t_data, sC.t_strb, sC.t_keep, sC.t_last, sC.t_user};
  assign sDPay = {sD.t_id, sD.t_dest, sD.t_data, sD.t_strb, sD.t_keep, sD.t_last, sD.t_user};

  beat_t         qA[$];
  beat_t         qB[$];
  int            pushesA, popsA, pushesB, popsB;
  bit            latA;
  logic [PW-1:0] beatsB [1000];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to timestamp accepted beats for the latency check.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat n for the FULL-stage tests: data carries n, last marks beat 9.
  function automatic logic [PW-1:0] beatA(input int n);
    logic [31:0] d;
    d = 32'(n);
    return {d[3:0], d[2:0], d, 4'hF, 4'hF, (n == 9), d[1:0]};
  endfunction

  task automatic applyStimulus(input logic [PW-1:0] p, input logic v);
    {mA.t_id, mA.t_dest, mA.t_data, mA.t_strb, mA.t_keep, mA.t_last, mA.t_user} = p;
    mA.t_valid = v;
  endtask

  task automatic driveB(input logic [PW-1:0] p, input logic v);
    {mB.t_id, mB.t_dest, mB.t_data, mB.t_strb, mB.t_keep, mB.t_last, mB.t_user} = p;
    mB.t_valid = v;
  endtask

  task automatic driveCD(input logic [PW-1:0] p, input logic v, input logic rdy);
    {mC.t_id, mC.t_dest, mC.t_data, mC.t_strb, mC.t_keep, mC.t_last, mC.t_user} = p;
    {mD.t_id, mD.t_dest, mD.t_data, mD.t_strb, mD.t_keep, mD.t_last, mD.t_user} = p;
    mC.t_valid = v;
    mD.t_valid = v;
    sC.t_ready = rdy;
    sD.t_ready = rdy;
  endtask

  // Scoreboard for uA: push accepted beats, pop and compare on output handshakes,
  // and optionally check the one-cycle latency of a FULL stage.
  always @(negedge clk) begin
    beat_t e;
    if (mA.t_valid && mA.t_ready) begin
      qA.push_back('{pay: mAPay, cyc: cyc});
      pushesA++;
    end
    if (sA.t_valid && sA.t_ready) begin
      popsA++;
      if (qA.size() == 0) begin
        total++;
        bad++;
        $error("[TB] FAIL A spurious observed=%0h expected=none", sAPay);
      end else begin
        e = qA.pop_front();
        checkOutput("A payload", 64'(sAPay), 64'(e.pay));
        if (latA) checkOutput("A latency", 64'(cyc - e.cyc), 64'd1);
      end
    end
  end

  // Scoreboard for uB plus the rule that a stalled output holds valid and payload.
  always @(negedge clk) begin
    beat_t         e;
    bit            stallB;
    logic [PW-1:0] prevB;
    if (stallB) begin
      checkOutput("B stall valid", 64'(sB.t_valid), 64'd1);
      checkOutput("B stall payload", 64'(sBPay), 64'(prevB));
    end
    stallB = sB.t_valid && !sB.t_ready;
    prevB  = sBPay;
    if (mB.t_valid && mB.t_ready) begin
      qB.push_back('{pay: mBPay, cyc: cyc});
      pushesB++;
    end
    if (sB.t_valid && sB.t_ready) begin
      popsB++;
      if (qB.size() == 0) begin
        total++;
        bad++;
        $error("[TB] FAIL B spurious observed=%0h expected=none", sBPay);
      end else begin
        e = qB.pop_front();
        checkOutput("B payload", 64'(sBPay), 64'(e.pay));
      end
    end
  end

  initial begin
    int            base;
    logic [63:0]   r;
    logic          v, rd;

    total = 0; bad = 0; cyc = 0; latA = 1'b1;
    pushesA = 0; popsA = 0; pushesB = 0; popsB = 0;
    for (int i = 0; i < 1000; i++) begin
      r = {$urandom(), $urandom()};
      beatsB[i] = r[PW-1:0];
    end
    rstn = 1'b0;
    applyStimulus('0, 1'b0);
    driveB('0, 1'b0);
    driveCD('0, 1'b0, 1'b0);
    sA.t_ready = 1'b0;
    sB.t_ready = 1'b0;

    // Reset state
    #3;
    checkOutput("reset A out valid", 64'(sA.t_valid), 64'd0);
    checkOutput("reset A full ready", 64'(mA.t_ready), 64'd0);
    checkOutput("reset B out valid", 64'(sB.t_valid), 64'd0);
    checkOutput("reset B forward ready", 64'(mB.t_ready), 64'd1);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    #1 checkOutput("release A ready before edge", 64'(mA.t_ready), 64'd0);
    @(posedge clk); #1;
    checkOutput("release A ready after edge", 64'(mA.t_ready), 64'd1);

    // Test 1: ten beats through the FULL stage with the sink always ready
    $display("[TB] test 1: FULL stage streaming");
    sA.t_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      applyStimulus(beatA(n), 1'b1);
      @(negedge clk);
      checkOutput("t1 ready", 64'(mA.t_ready), 64'd1);
      @(posedge clk); #1;
    end
    applyStimulus(beatA(0), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t1 beats out", 64'(popsA), 64'd10);
    checkOutput("t1 queue empty", 64'(qA.size()), 64'd0);

    // Test 2: sink stalled while three beats are offered; only two fit
    $display("[TB] test 2: FULL stage backpressure");
    latA = 1'b0;
    base = pushesA;
    sA.t_ready = 1'b0;
    applyStimulus(beatA(10), 1'b1);
    @(negedge clk) checkOutput("t2 ready beat0", 64'(mA.t_ready), 64'd1);
    @(posedge clk); #1;
    applyStimulus(beatA(11), 1'b1);
    @(negedge clk) checkOutput("t2 ready beat1", 64'(mA.t_ready), 64'd1);
    @(posedge clk); #1;
    applyStimulus(beatA(12), 1'b1);
    @(negedge clk) checkOutput("t2 ready full", 64'(mA.t_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t2 ready still full", 64'(mA.t_ready), 64'd0);
    checkOutput("t2 hold valid", 64'(sA.t_valid), 64'd1);
    checkOutput("t2 hold payload", 64'(sAPay), 64'(beatA(10)));
    checkOutput("t2 accepted", 64'(pushesA - base), 64'd2);
    @(posedge clk); #1;
    sA.t_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    applyStimulus(beatA(12), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t2 total accepted", 64'(pushesA - base), 64'd3);
    checkOutput("t2 all drained", 64'(popsA), 64'(pushesA));
    checkOutput("t2 queue empty", 64'(qA.size()), 64'd0);

    // Test 4: reset with two beats buffered in the FULL stage
    $display("[TB] test 4: reset mid-stream");
    sA.t_ready = 1'b0;
    applyStimulus(beatA(20), 1'b1);
    @(posedge clk); #1;
    applyStimulus(beatA(21), 1'b1);
    @(posedge clk); #1;
    applyStimulus(beatA(21), 1'b0);
    checkOutput("t4 buffered valid", 64'(sA.t_valid), 64'd1);
    checkOutput("t4 buffered ready", 64'(mA.t_ready), 64'd0);
    #2 rstn = 1'b0;
    #1;
    checkOutput("t4 async valid drop", 64'(sA.t_valid), 64'd0);
    checkOutput("t4 ready in reset", 64'(mA.t_ready), 64'd0);
    qA.delete();
    @(posedge clk);
    #3 rstn = 1'b1;
    #1 checkOutput("t4 ready before edge", 64'(mA.t_ready), 64'd0);
    @(posedge clk); #1;
    checkOutput("t4 ready after edge", 64'(mA.t_ready), 64'd1);
    checkOutput("t4 nothing buffered", 64'(sA.t_valid), 64'd0);
    latA = 1'b1;
    base = popsA;
    sA.t_ready = 1'b1;
    applyStimulus(beatA(30), 1'b1);
    @(posedge clk); #1;
    applyStimulus(beatA(30), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t4 beats after reset", 64'(popsA - base), 64'd1);
    checkOutput("t4 queue empty", 64'(qA.size()), 64'd0);

    // Test 3: three FORWARD stages, random valid/ready, 1000 beats
    $display("[TB] test 3: FORWARD random traffic");
    for (int c = 0; c < 20000 && popsB < 1000; c++) begin
      if (pushesB < 1000) driveB(beatsB[pushesB], 1'($urandom_range(0, 1)));
      else driveB(beatsB[999], 1'b0);
      sB.t_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    driveB(beatsB[0], 1'b0);
    sB.t_ready = 1'b0;
    checkOutput("t3 beats out", 64'(popsB), 64'd1000);
    checkOutput("t3 queue empty", 64'(qB.size()), 64'd0);

    // Test 5: DEPTH=0 and PASS stages behave as wires
    $display("[TB] test 5: combinational equivalence");
    for (int k = 0; k < 6; k++) begin
      r  = {$urandom(), $urandom()};
      v  = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      driveCD(r[PW-1:0], v, rd);
      #2;
      checkOutput("t5 C payload", 64'(sCPay), 64'(r[PW-1:0]));
      checkOutput("t5 C valid", 64'(sC.t_valid), 64'(v));
      checkOutput("t5 C ready", 64'(mC.t_ready), 64'(rd));
      checkOutput("t5 D payload", 64'(sDPay), 64'(r[PW-1:0]));
      checkOutput("t5 D valid", 64'(sD.t_valid), 64'(v));
      checkOutput("t5 D ready", 64'(mD.t_ready), 64'(rd));
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
